id_hazard_ctrl: RTL and testbench

- Registered decode/issue stage for the 5-stage MIPS core; sits between IF and EX.
- Accepts one instruction per cycle over a valid/ready handshake and classifies it (loads, stores, R-type, I-type ALU, link instructions, HI/LO ops).
- Keeps a shift-register scoreboard of in-flight destinations and a HI/LO busy counter, and stalls IF on load-use and mult/div hazards.
- Issues a registered decode bundle to EX.

---
 rtl/id_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl
// Description : Registered decode/issue stage of the 5-stage MIPS core,
//               between IF and EX. Classifies each instruction, tracks
//               in-flight destinations in a shift-register scoreboard and
//               keeps a HI/LO busy counter; stalls IF on load-use and
//               mult/div hazards, and issues a registered bundle to EX.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : SB_DEPTH  scoreboard entries (0=EX, 1=MEM, 2=WB), >= 2
//               MD_LAT    HI/LO busy cycles after a mult/div issue, >= 1
// Macro       : MEM_FWD_EN  load data is forwarded from MEM, so only a match
//               with entry 0 stalls. Undefined: entries 0..SB_DEPTH-2 stall.
// Ports       : clk, rst            clock, async active-high reset
//               in_valid/in_inst/in_pc   instruction from IF
//               in_ready            accept this cycle (= !stall)
//               out_*               registered issue bundle to EX
//               stall               hazard on the current in_inst
//               md_busy             HI/LO unit busy (counter nonzero)
// ============================================================================
module id_hazard_ctrl #(
    parameter int SB_DEPTH = 3,
    parameter int MD_LAT   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_reg_write,
    output logic [4:0]  out_wdest,
    output logic        out_mem_read,
    output logic        out_md_start,
    output logic        stall,
    output logic        md_busy
);

    localparam int c_MD_W = $clog2(MD_LAT + 1);
    localparam logic [c_MD_W-1:0] c_MD_LOAD = c_MD_W'(MD_LAT);
    localparam logic [c_MD_W-1:0] c_MD_ONE  = c_MD_W'(1);
`ifdef MEM_FWD_EN
    localparam int c_LU_DEPTH = 1;
`else
    localparam int c_LU_DEPTH = SB_DEPTH - 1;
`endif

    // ------------------------------------------------------------------
    // Field extraction and instruction classes
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;

    assign w_op = in_inst[31:26];
    assign w_rs = in_inst[25:21];
    assign w_rt = in_inst[20:16];
    assign w_rd = in_inst[15:11];
    assign w_fn = in_inst[5:0];

    logic w_is_load;
    logic w_is_store;
    logic w_is_r;
    logic w_is_link;
    logic w_is_ialu;
    logic w_is_md;
    logic w_is_hilo;
    logic w_r_nodest;

    assign w_is_load  = (w_op[5:3] == 3'b100);
    assign w_is_store = (w_op[5:3] == 3'b101);
    assign w_is_r     = (w_op == 6'b000000);
    assign w_is_ialu  = (w_op[5:3] == 3'b001);
    // jal, or REGIMM bltzal/bgezal
    assign w_is_link  = (w_op == 6'b000011) ||
                        ((w_op == 6'b000001) && ((w_rt == 5'b10000) || (w_rt == 5'b10001)));
    // mult/multu/div/divu occupy funct 0110xx
    assign w_is_md    = w_is_r && (w_fn[5:2] == 4'b0110);
    // mfhi/mthi/mflo/mtlo
    assign w_is_hilo  = w_is_r && ((w_fn == 6'b010000) || (w_fn == 6'b010001) ||
                                   (w_fn == 6'b010010) || (w_fn == 6'b010011));
    // R-type ops that produce no GPR result: mult/div, mthi/mtlo, jr
    assign w_r_nodest = w_is_md || (w_fn == 6'b010001) || (w_fn == 6'b010011) ||
                        (w_fn == 6'b001000);

    // ------------------------------------------------------------------
    // Destination and source usage
    // ------------------------------------------------------------------
    logic [4:0] w_dest;
    logic       w_reg_write;
    logic       w_use_rs;
    logic       w_use_rt;

    always_comb begin
        w_dest = 5'd0;
        if (w_is_r) begin
            if (!w_r_nodest) begin
                w_dest = w_rd;
            end
        end else if (w_is_link) begin
            w_dest = 5'd31;
        end else if (w_is_load || w_is_ialu) begin
            w_dest = w_rt;
        end
    end

    // A zero destination doubles as "no destination"
    assign w_reg_write = (w_dest != 5'd0);

    // j, jal, lui and the immediate shifts do not read rs
    assign w_use_rs = !((w_op == 6'b000010) || (w_op == 6'b000011) || (w_op == 6'b001111) ||
                        (w_is_r && ((w_fn == 6'b000000) || (w_fn == 6'b000010) ||
                                    (w_fn == 6'b000011))));
    assign w_use_rt = w_is_r || (w_op == 6'b000100) || (w_op == 6'b000101) || w_is_store ||
                      (w_op == 6'b100010) || (w_op == 6'b100110);

    // ------------------------------------------------------------------
    // Scoreboard and HI/LO counter state
    // ------------------------------------------------------------------
    logic [SB_DEPTH-1:0] r_sb_valid;
    logic [SB_DEPTH-1:0] r_sb_load;
    logic [SB_DEPTH-1:0] r_sb_wr;
    logic [4:0]          r_sb_dest [SB_DEPTH];
    logic [c_MD_W-1:0]   r_md_cnt;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_lu_hazard;
    logic w_md_hazard;
    logic w_accept;

    // Only loads stall; ALU results are forwarded. Entries at or beyond
    // c_LU_DEPTH already have their load data available by forwarding.
    always_comb begin
        w_lu_hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((i < c_LU_DEPTH) && r_sb_valid[i] && r_sb_load[i] && r_sb_wr[i]) begin
                if (w_use_rs && (w_rs != 5'd0) && (r_sb_dest[i] == w_rs)) begin
                    w_lu_hazard = 1'b1;
                end
                if (w_use_rt && (w_rt != 5'd0) && (r_sb_dest[i] == w_rt)) begin
                    w_lu_hazard = 1'b1;
                end
            end
        end
    end

    assign md_busy     = (r_md_cnt != '0);
    assign w_md_hazard = (w_is_md || w_is_hilo) && md_busy;
    assign stall       = in_valid && (w_lu_hazard || w_md_hazard);
    assign in_ready    = !stall;
    assign w_accept    = in_valid && !stall;

    // ------------------------------------------------------------------
    // Scoreboard shift: a bubble enters entry 0 whenever nothing issues
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_valid <= '0;
            r_sb_load  <= '0;
            r_sb_wr    <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb_dest[i] <= 5'd0;
            end
        end else begin
            r_sb_valid <= {r_sb_valid[SB_DEPTH-2:0], w_accept};
            r_sb_load  <= {r_sb_load[SB_DEPTH-2:0],  w_accept && w_is_load};
            r_sb_wr    <= {r_sb_wr[SB_DEPTH-2:0],    w_accept && w_reg_write};
            for (int i = SB_DEPTH - 1; i > 0; i--) begin
                r_sb_dest[i] <= r_sb_dest[i-1];
            end
            r_sb_dest[0] <= w_accept ? w_dest : 5'd0;
        end
    end

    // ------------------------------------------------------------------
    // HI/LO busy counter. A mult/div can only be accepted with the
    // counter at zero, so load and decrement never coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_cnt <= '0;
        end else if (w_accept && w_is_md) begin
            r_md_cnt <= c_MD_LOAD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - c_MD_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Issue bundle register. Control flags are cleared on bubbles so EX
    // never acts on stale qualifiers; inst/pc/wdest simply hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_inst      <= 32'd0;
            out_pc        <= 32'd0;
            out_reg_write <= 1'b0;
            out_wdest     <= 5'd0;
            out_mem_read  <= 1'b0;
            out_md_start  <= 1'b0;
        end else begin
            out_valid <= w_accept;
            if (w_accept) begin
                out_inst      <= in_inst;
                out_pc        <= in_pc;
                out_reg_write <= w_reg_write;
                out_wdest     <= w_dest;
                out_mem_read  <= w_is_load;
                out_md_start  <= w_is_md;
            end else begin
                out_reg_write <= 1'b0;
                out_mem_read  <= 1'b0;
                out_md_start  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_ctrl
// Description : Self-checking bench for id_hazard_ctrl. A reference model
//               tracks load issue times per register and the HI/LO free
//               time; accepted instructions push their expected bundle into
//               a queue that an independent monitor pops on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    localparam int SB  = 3;
    localparam int LAT = 4;
`ifdef MEM_FWD_EN
    localparam int WIN = 1;
`else
    localparam int WIN = SB - 1;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_reg_write;
    logic [4:0]  out_wdest;
    logic        out_mem_read;
    logic        out_md_start;
    logic        stall;
    logic        md_busy;

    id_hazard_ctrl #(.SB_DEPTH(SB), .MD_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_reg_write(out_reg_write),
        .out_wdest    (out_wdest),
        .out_mem_read (out_mem_read),
        .out_md_start (out_md_start),
        .stall        (stall),
        .md_busy      (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference decode, straight from the instruction-set rules
    // ---------------------------------------------------------------
    typedef struct {
        logic       ld;
        logic       md;
        logic       hilo;
        logic       use_rs;
        logic       use_rt;
        logic       rw;
        logic [4:0] wd;
        logic [4:0] rs;
        logic [4:0] rt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rd;
        logic       has;
        logic [4:0] dst;
        op  = w[31:26];
        fn  = w[5:0];
        rd  = w[15:11];
        d.rs = w[25:21];
        d.rt = w[20:16];
        d.ld   = op inside {[6'b100000:6'b100111]};
        d.md   = (op == 6'd0) && (fn inside {[6'b011000:6'b011011]});
        d.hilo = (op == 6'd0) && (fn inside {6'b010000, 6'b010001, 6'b010010, 6'b010011});
        has = 1'b0;
        dst = 5'd0;
        if (op == 6'd0) begin
            has = !(d.md || (fn inside {6'b010001, 6'b010011, 6'b001000}));
            dst = rd;
        end else if (op == 6'b000011 || (op == 6'b000001 && (d.rt inside {5'b10000, 5'b10001}))) begin
            has = 1'b1;
            dst = 5'd31;
        end else if (d.ld || (op inside {[6'b001000:6'b001111]})) begin
            has = 1'b1;
            dst = d.rt;
        end
        d.wd = has ? dst : 5'd0;
        d.rw = has && (dst != 5'd0);
        d.use_rs = !((op inside {6'b000010, 6'b000011, 6'b001111}) ||
                     (op == 6'd0 && (fn inside {6'b000000, 6'b000010, 6'b000011})));
        d.use_rt = (op == 6'd0) || (op inside {6'b000100, 6'b000101, [6'b101000:6'b101111],
                                               6'b100010, 6'b100110});
        return d;
    endfunction

    // ---------------------------------------------------------------
    // Timing model: cycle number of the most recent load to each
    // register, and the first cycle the HI/LO unit is free again.
    // ---------------------------------------------------------------
    int cyc = 0;
    int load_cyc [32];
    int md_free  = -1;
    logic [31:0] pc_ctr = 32'h0040_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  wd;
        logic        mr;
        logic        ms;
    } bun_t;

    bun_t q[$];
    logic last_acc = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) load_cyc[i] = -100000;
        md_free = -1;
    endtask

    function automatic logic src_waits(input logic used, input logic [4:0] r);
        int age;
        age = cyc - load_cyc[r];
        return used && (r != 5'd0) && (age >= 1) && (age <= WIN);
    endfunction

    // One clock of stimulus with per-cycle checks of the combinational outputs
    task automatic step(input logic v, input logic [31:0] w, output logic acc);
        dec_t d;
        logic eb;
        logic es;
        bun_t b;
        @(posedge clk);
        #1;
        in_valid = v;
        in_inst  = w;
        in_pc    = pc_ctr;
        @(negedge clk);
        d  = decode(w);
        eb = (cyc < md_free);
        es = v && (src_waits(d.use_rs, d.rs) || src_waits(d.use_rt, d.rt) ||
                   ((d.md || d.hilo) && eb));
        chk("stall", stall, es);
        chk("in_ready", in_ready, !es);
        chk("md_busy", md_busy, eb);
        acc = v && !es;
        if (acc) begin
            b.inst = w;
            b.pc   = pc_ctr;
            b.rw   = d.rw;
            b.wd   = d.wd;
            b.mr   = d.ld;
            b.ms   = d.md;
            q.push_back(b);
            if (d.ld) load_cyc[d.wd] = cyc;
            if (d.md) md_free = cyc + LAT + 1;
            pc_ctr += 32'd4;
        end
        last_acc = acc;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, a);
    endtask

    // Present an instruction until accepted; returns observed stall cycles
    task automatic issue(input logic [31:0] w, output int nst);
        logic a;
        nst = 0;
        for (int k = 0; k < 200; k++) begin
            step(1'b1, w, a);
            if (stall === 1'b1) nst++;
            if (a) return;
        end
        total++;
        bad++;
        $display("FAIL issue_timeout: inst %0h not accepted, required within 200 cycles", w);
    endtask

    task automatic do_reset_mid();
        #1 rst = 1'b1;
        #1;
        chk("rst_md_busy", md_busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        last_acc = 1'b0;
        q.delete();
        model_clear();
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc += 2;
    endtask

    // ---------------------------------------------------------------
    // Monitor: compares every issued bundle against the queue head
    // ---------------------------------------------------------------
    initial begin
        bun_t e;
        forever begin
            @(posedge clk);
            #3;
            chk("out_valid", out_valid, last_acc);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got inst %0h, required no issue", out_inst);
                end else begin
                    e = q.pop_front();
                    chk("out_inst", out_inst, e.inst);
                    chk("out_pc", out_pc, e.pc);
                    chk("out_reg_write", out_reg_write, e.rw);
                    chk("out_wdest", out_wdest, e.wd);
                    chk("out_mem_read", out_mem_read, e.mr);
                    chk("out_md_start", out_md_start, e.ms);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Encoders and random instruction generator
    // ---------------------------------------------------------------
    function automatic logic [31:0] rt_i(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [4:0] rr();
        return 5'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] hl [4];
        logic [4:0] ri [4];
        hl[0] = 6'b010000; hl[1] = 6'b010001; hl[2] = 6'b010010; hl[3] = 6'b010011;
        ri[0] = 5'b10000;  ri[1] = 5'b10001;  ri[2] = 5'b00001;  ri[3] = 5'b00000;
        case ($urandom_range(0, 11))
            0:  return {3'b100, 3'($urandom), rr(), rr(), 16'($urandom)};
            1:  return {3'b101, 3'($urandom), rr(), rr(), 16'($urandom)};
            2:  return rt_i(rr(), rr(), rr(), 5'd0, 6'b100001);
            3:  return rt_i(5'($urandom), rr(), rr(), 5'($urandom), {4'b0000, 2'($urandom)});
            4:  return rt_i(rr(), 5'd0, 5'd0, 5'd0, 6'b001000);
            5:  return rt_i(rr(), rr(), 5'd0, 5'd0, {4'b0110, 2'($urandom)});
            6:  return rt_i(rr(), 5'd0, rr(), 5'd0, hl[$urandom_range(0, 3)]);
            7:  return {3'b001, 3'($urandom), rr(), rr(), 16'($urandom)};
            8:  return {5'b00010, 1'($urandom), rr(), rr(), 16'($urandom)};
            9:  return {5'b00001, 1'($urandom), 26'($urandom)};
            10: return it_i(6'b000001, rr(), ri[$urandom_range(0, 3)], 16'($urandom));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Main stimulus
    // ---------------------------------------------------------------
    initial begin
        int          n;
        logic        a;
        logic        have;
        logic [31:0] cur;
        logic        v;

        model_clear();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_inst  = 32'd0;
        in_pc    = 32'd0;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_reg_write", out_reg_write, 1'b0);
        chk("reset_out_wdest", out_wdest, 5'd0);
        chk("reset_out_inst", out_inst, 32'd0);
        chk("reset_md_busy", md_busy, 1'b0);
        chk("reset_stall", stall, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // load-use: lw $2,0($1) ; addu $3,$2,$4
        issue(it_i(6'b100011, 5'd1, 5'd2, 16'd0), n);
        issue(rt_i(5'd2, 5'd4, 5'd3, 5'd0, 6'b100001), n);
        chk("loaduse_stall_cycles", n, WIN);
        idle(3);

        // ALU dependency: addiu $5,$0,1 ; addu $6,$5,$5
        issue(it_i(6'b001001, 5'd0, 5'd5, 16'd1), n);
        issue(rt_i(5'd5, 5'd5, 5'd6, 5'd0, 6'b100001), n);
        chk("alu_dep_stall_cycles", n, 0);
        idle(3);

        // zero register: lw $0,0($1) ; addu $3,$0,$0
        issue(it_i(6'b100011, 5'd1, 5'd0, 16'd0), n);
        issue(rt_i(5'd0, 5'd0, 5'd3, 5'd0, 6'b100001), n);
        chk("zero_reg_stall_cycles", n, 0);
        idle(3);

        // HI/LO: mult $1,$2 ; mflo $3 ; mult ; mult
        issue(rt_i(5'd1, 5'd2, 5'd0, 5'd0, 6'b011000), n);
        issue(rt_i(5'd0, 5'd0, 5'd3, 5'd0, 6'b010010), n);
        chk("mflo_stall_cycles", n, LAT);
        issue(rt_i(5'd1, 5'd2, 5'd0, 5'd0, 6'b011000), n);
        issue(rt_i(5'd3, 5'd4, 5'd0, 5'd0, 6'b011001), n);
        chk("mult_mult_stall_cycles", n, LAT);
        idle(LAT + 2);

        // link and shifts
        issue({6'b000011, 26'h0123456}, n);
        issue(it_i(6'b100011, 5'd1, 5'd9, 16'd8), n);
        issue(rt_i(5'd0, 5'd2, 5'd4, 5'd3, 6'b000000), n);
        chk("sll_after_lw_stall_cycles", n, 0);
        idle(3);

        // reset during md countdown with a load in entry 0
        issue(rt_i(5'd1, 5'd2, 5'd0, 5'd0, 6'b011000), n);
        issue(it_i(6'b100011, 5'd1, 5'd2, 16'd0), n);
        step(1'b1, rt_i(5'd2, 5'd2, 5'd3, 5'd0, 6'b100001), a);
        chk("pre_reset_stall", stall, 1'b1);
        do_reset_mid();
        issue(rt_i(5'd0, 5'd0, 5'd3, 5'd0, 6'b010010), n);
        chk("post_reset_mflo_stall_cycles", n, 0);
        idle(3);

        // randomized traffic; IF holds an instruction until accepted
        have = 1'b0;
        cur  = 32'd0;
        for (int i = 0; i < 800; i++) begin
            if (!have) begin
                cur  = rand_inst();
                have = 1'b1;
            end
            v = ($urandom_range(0, 9) < 8);
            step(v, cur, a);
            if (a) have = 1'b0;
        end

        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
